lstm_mac_pe_lanes: RTL
======================

# lstm_mac_pe_lanes

Multi-lane fixed-point multiply-accumulate processing element for the LSTM/FC datapath. It broadcasts one input operand `x` to `LANES` parallel lanes; each lane has its own weight and bias. Each lane accumulates a dot product whose length is set at runtime, then rounds and saturates the result to `D_WL` bits. Results leave through a one-entry valid/ready output buffer with backpressure, so gate units can consume them at their own pace.

## Interface
- `LANES`, 4: number of parallel MAC lanes (output neurons).
- `D_WL`, 16: data/weight/bias/output word length, two's complement.
- `FL`, 12: fractional bits of `x`, `w`, `b` and `d_o`.
- `MAX_LEN`, 256: maximum dot-product length.
- `ACC_WL`, 40: accumulator width. Must be ≥ 2*D_WL + clog2(MAX_LEN).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_len`  in  clog2(MAX_LEN+1)  vector length. Sampled on the first beat of each vector.
- `flush`  in  1  synchronous discard of the partial vector.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `x`  in  D_WL  shared operand.
- `w`  in  LANES*D_WL  per-lane weights. Lane i occupies `[i*D_WL +: D_WL]`.
- `b`  in  LANES*D_WL  per-lane bias. Sampled on the first beat only.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `d_o`  out  LANES*D_WL  per-lane results.
- `sat_o`  out  LANES  per-lane saturation flag. Qualified by `out_valid`.

## Operation
- **Beat counter `cnt`:** range 0..len-1. It advances on each accepted beat and wraps to 0 after the last beat.
- **Length latch:** `len` is latched from `cfg_len` on the beat where `cnt==0`. A value of 0 is treated as 1. Values above `MAX_LEN` are clamped to `MAX_LEN`.
- **Product:** the full-precision signed product `x*w` is 2*D_WL bits, sign-extended to `ACC_WL`.
- **First beat (`cnt==0`):** `acc <= x*w + (b sign-extended, shifted left by FL)`.
- **Later beats:** `acc <= acc + x*w`.
- **Last beat (`cnt==len-1`):**
  - Compute the final sum `s` (the same value written to `acc`).
  - Round: `r = (s + 2^(FL-1)) >>> FL` (round half up).
  - Saturate `r` to [-2^(D_WL-1), 2^(D_WL-1)-1].
  - Set `sat_o[i]` when lane i clipped.
  - Load `d_o` and `sat_o`, and set `out_valid`.
- **Output buffer:** single entry. `out_valid` clears on `out_valid && out_ready` unless a new last beat loads it in the same cycle.
- **Backpressure:** `in_ready = !(out_valid && !out_ready && cnt==len_eff-1)`.
  - Non-final beats are always accepted while a result is pending; only the final beat stalls.
  - `len_eff` is the latched `len`, or the clamped `cfg_len` when `cnt==0`.
- **Flush:** `flush` forces `cnt<=0` and drops any beat presented in that cycle. It does not affect `out_valid`/`d_o`. Flush takes priority over an accepted beat.
- **Reset values:** `cnt` 0, `acc` 0, `len` 1, `d_o` 0, `sat_o` 0, `out_valid` 0. After reset, `in_ready` is 1.

## Timing
- **Latency:** last beat accepted in cycle T produces `out_valid=1` with valid `d_o` in cycle T+1.
- **Throughput:** one beat per cycle. Back-to-back vectors run with no bubble when `out_ready` is held at 1.
- **Simultaneous events:** with `out_valid && out_ready` and a last beat accepted in the same cycle, the new result replaces the old one at T+1 and `out_valid` stays 1.
- **Stable output:** `d_o`/`sat_o` hold stable while `out_valid && !out_ready`.
- **Mid-operation reset:** `rst_n` low discards the partial vector and any pending result in that cycle.

## Structure
- **Package `lstm_mac_pkg`:**
  - default `D_WL`/`FL` constants;
  - function `round_sat(s, ACC_WL, D_WL, FL)` returning `{sat, q}`;
  - localparam `LEN_W = $clog2(MAX_LEN+1)`.
- **Sub-module `lstm_mac_lane`:** one lane, covering product, accumulator and round/saturate. It is instantiated `LANES` times in a generate loop.
- **Top level:** the counter, length latch, handshake and output buffer stay in the top.

## Test plan
- **Basic dot product:** D_WL=16, FL=12, len=3; lane 0 with x=1.0 (0x1000), w=0.5 (0x0800) each beat, b=0.25 (0x0400) → `d_o[0]`=0x1C00 (1.75) at T+1, `sat_o`=0.
- **Rounding:** len=1, x=0x0001, w=0x0800, b=0 → product = 2^11 → r=1 (half rounds up). With w=0xF800 (-0.5), product = -2^11 → r=0.
- **Saturation:** len=4, x=0x7FFF, w=0x7FFF on every beat in all lanes → `d_o` lanes = 0x7FFF, `sat_o`=4'b1111. Negated w → `d_o` lanes = 0x8000, flags set.
- **Backpressure:** two len=2 vectors back-to-back with `out_ready=0` → the second vector's first beat is accepted and its last beat stalls with `in_ready=0`. The first result holds. Raising `out_ready` for one cycle accepts the stalled beat, and the second result appears the next cycle.
- **Flush, zero length, reset:**
  - `flush` after beat 1 of len=4 → the next beat restarts with the bias.
  - `cfg_len=0` → a result after every beat.
  - `rst_n` low mid-vector → all outputs 0 the next cycle.

Source files
------------

// File: rtl/lstm_mac_pkg.sv
// lstm_mac_pkg
// Shared constants and the round/saturate helper for the LSTM MAC lanes.
// Contents:
//   DEF_D_WL / DEF_FL / DEF_MAX_LEN : default word length, fraction bits, max length
//   LEN_W                           : width of a length value covering 0..MAX_LEN
//   RS_W                            : width of the round_sat result {sat, q}
//   round_sat(s, acc_wl, d_wl, fl)  : round half up, then saturate to d_wl bits
package lstm_mac_pkg;

    localparam int DEF_D_WL    = 16;
    localparam int DEF_FL      = 12;
    localparam int DEF_MAX_LEN = 256;
    localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);

    // Result is {sat, q[31:0]}; q is sign-extended to 32 bits, so callers
    // keep the low d_wl bits.
    localparam int RS_W = 33;

    // s carries an acc_wl-bit sum in its low bits. It is re-sign-extended from
    // bit acc_wl-1 so the caller may pass it either sign- or zero-extended.
    function automatic logic [RS_W-1:0] round_sat(input logic signed [63:0] s,
                                                  input int acc_wl,
                                                  input int d_wl,
                                                  input int fl);
        logic signed [63:0] se;
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic               sat;
        logic        [31:0] q;
        se    = (s <<< (64 - acc_wl)) >>> (64 - acc_wl);
        r     = (se + (64'sd1 <<< (fl - 1))) >>> fl;
        max_v = (64'sd1 <<< (d_wl - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (d_wl - 1));
        if (r > max_v) begin
            sat = 1'b1;
            q   = max_v[31:0];
        end else if (r < min_v) begin
            sat = 1'b1;
            q   = min_v[31:0];
        end else begin
            sat = 1'b0;
            q   = r[31:0];
        end
        return {sat, q};
    endfunction

endpackage

// File: rtl/lstm_mac_pe_lanes_lane.sv
// lstm_mac_lane
// One MAC lane: signed product, accumulator and round/saturate of the running
// sum. The rounded value always reflects the sum being written this cycle;
// the top decides when to capture it.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en_i       : an accepted (non-flushed) beat this cycle
//   first_i    : this beat starts a vector (load bias instead of accumulating)
//   x_i, w_i   : shared operand and this lane's weight
//   b_i        : this lane's bias (used on the first beat only)
//   q_o, sat_o : rounded/saturated sum and clip flag for this cycle's sum
module lstm_mac_lane
    import lstm_mac_pkg::*;
#(
    parameter int D_WL   = 16,
    parameter int FL     = 12,
    parameter int ACC_WL = 40
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic                   first_i,
    input  logic signed [D_WL-1:0] x_i,
    input  logic signed [D_WL-1:0] w_i,
    input  logic signed [D_WL-1:0] b_i,
    output logic        [D_WL-1:0] q_o,
    output logic                   sat_o
);

    logic signed [2*D_WL-1:0] prod;
    logic signed [ACC_WL-1:0] prod_ext;
    logic signed [ACC_WL-1:0] bias_ext;
    logic signed [ACC_WL-1:0] acc_q;
    logic signed [ACC_WL-1:0] acc_d;
    logic        [RS_W-1:0]   rs;
    logic                     unused_rs_hi;

    assign prod     = x_i * w_i;
    assign prod_ext = {{(ACC_WL - 2*D_WL){prod[2*D_WL-1]}}, prod};
    // Bias is aligned to the product's 2*FL fraction bits.
    assign bias_ext = {{(ACC_WL - D_WL - FL){b_i[D_WL-1]}}, b_i, {FL{1'b0}}};
    assign acc_d    = first_i ? (prod_ext + bias_ext) : (acc_q + prod_ext);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign rs           = round_sat({{(64 - ACC_WL){acc_d[ACC_WL-1]}}, acc_d}, ACC_WL, D_WL, FL);
    assign q_o          = rs[D_WL-1:0];
    assign sat_o        = rs[RS_W-1];
    assign unused_rs_hi = ^rs[31:D_WL];

endmodule

// File: rtl/lstm_mac_pe_lanes.sv
// lstm_mac_pe_lanes
// Multi-lane fixed-point MAC processing element. One operand x is broadcast
// to LANES lanes with per-lane weight and bias; each lane accumulates a
// runtime-length dot product, rounds and saturates to D_WL bits, and the
// results leave through a one-entry output buffer.
// Handshake: an input beat transfers when in_valid && in_ready; a result
// transfers when out_valid && out_ready. Only the final beat of a vector
// stalls while an unconsumed result is pending.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   cfg_len              : vector length, sampled on the first beat
//   flush                : drop the partial vector and any beat this cycle
//   in_valid / in_ready  : input beat handshake
//   x, w, b              : shared operand, per-lane weights, per-lane biases
//   out_valid / out_ready: result handshake
//   d_o, sat_o           : per-lane results and clip flags
module lstm_mac_pe_lanes
    import lstm_mac_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int D_WL    = DEF_D_WL,
    parameter int FL      = DEF_FL,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int ACC_WL  = 40,
    localparam int L_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [L_W-1:0]          cfg_len,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [D_WL-1:0]         x,
    input  logic [LANES*D_WL-1:0]   w,
    input  logic [LANES*D_WL-1:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*D_WL-1:0]   d_o,
    output logic [LANES-1:0]        sat_o
);

    localparam logic [L_W-1:0] MAX_LEN_L = L_W'(MAX_LEN);
    localparam logic [L_W-1:0] ONE_L     = L_W'(1);

    logic [L_W-1:0]        cnt_q, cnt_d;
    logic [L_W-1:0]        len_q, len_d;
    logic [L_W-1:0]        cfg_eff;
    logic [L_W-1:0]        len_eff;
    logic                  first_beat;
    logic                  last_beat;
    logic                  beat_acc;
    logic                  out_valid_q, out_valid_d;
    logic [LANES*D_WL-1:0] d_q, d_d;
    logic [LANES-1:0]      sat_q, sat_d;
    logic [LANES*D_WL-1:0] lane_q;
    logic [LANES-1:0]      lane_sat;

    assign cfg_eff    = (cfg_len == '0) ? ONE_L :
                        (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
    assign first_beat = (cnt_q == '0);
    // On the first beat the length has not been latched yet, so use cfg_len.
    assign len_eff    = first_beat ? cfg_eff : len_q;
    assign last_beat  = (cnt_q == len_eff - ONE_L);
    assign in_ready   = !(out_valid_q && !out_ready && last_beat);
    assign beat_acc   = in_valid && in_ready && !flush;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lstm_mac_lane #(
            .D_WL   (D_WL),
            .FL     (FL),
            .ACC_WL (ACC_WL)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (beat_acc),
            .first_i (first_beat),
            .x_i     (x),
            .w_i     (w[i*D_WL +: D_WL]),
            .b_i     (b[i*D_WL +: D_WL]),
            .q_o     (lane_q[i*D_WL +: D_WL]),
            .sat_o   (lane_sat[i])
        );
    end

    always_comb begin
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        d_d         = d_q;
        sat_d       = sat_q;
        if (flush) begin
            cnt_d = '0;
        end else if (beat_acc) begin
            if (first_beat) begin
                len_d = cfg_eff;
            end
            cnt_d = last_beat ? '0 : cnt_q + ONE_L;
        end
        // A new result takes priority over the consumer draining the old one.
        if (beat_acc && last_beat) begin
            out_valid_d = 1'b1;
            d_d         = lane_q;
            sat_d       = lane_sat;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            len_q       <= ONE_L;
            out_valid_q <= 1'b0;
            d_q         <= '0;
            sat_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign d_o       = d_q;
    assign sat_o     = sat_q;

endmodule
